down_counter: RTL

Loadable, synchronous, modulo-N down counter with start/stop control and terminal-count signalling. It is the counting-down counterpart to the counter library's ripple up counter, used for timeouts, programmable delays and periodic ticks. A small control FSM sequences load, run, pause and completion. All state is clocked on the rising edge of `clk`.

---
 rtl/counter_pkg.sv | 37 +++
 rtl/down_counter_fsm.sv | 99 +++++++++
 rtl/down_counter.sv | 82 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter library: FSM states, control priority and datapath selects.
// The control decode puts load ahead of stop, and stop ahead of start.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CTRL_NONE  = 2'd0,
    CTRL_START = 2'd1,
    CTRL_STOP  = 2'd2,
    CTRL_LOAD  = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_DEC    = 2'd1,
    SEL_LOAD   = 2'd2,
    SEL_RELOAD = 2'd3
  } sel_e;

  function automatic ctrl_e decode_ctrl(input logic load, input logic stop, input logic start);
    ctrl_e ctrl;
    if (load)       ctrl = CTRL_LOAD;
    else if (stop)  ctrl = CTRL_STOP;
    else if (start) ctrl = CTRL_START;
    else            ctrl = CTRL_NONE;
    return ctrl;
  endfunction

endpackage

// File: rtl/down_counter_fsm.sv
// Control FSM for the down counter: sequences load, run, pause and completion and
// tells the datapath whether to hold, decrement, load or reload the count.
module down_counter_fsm
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_reload,
  input  logic       q_zero,
  input  logic       q_one,
  input  logic       reload_nz,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic [1:0] sel
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  sel_e   sel_d;
  ctrl_e  ctrl;
  logic   can_reload;

  always_comb begin
    ctrl       = decode_ctrl(load, stop, start);
    can_reload = auto_reload && reload_nz;
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    sel_d      = SEL_HOLD;

    if (ctrl == CTRL_LOAD) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sel_d   = SEL_LOAD;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ctrl == CTRL_START && !q_zero) begin
            state_d = RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        RUN: begin
          // The zero state in RUN only exists between tc and the reload edge.
          if (ctrl == CTRL_STOP) begin
            state_d = HOLD;
          end else if (q_zero) begin
            if (can_reload) begin
              sel_d = SEL_RELOAD;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            sel_d = SEL_DEC;
            if (q_one && !can_reload) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (ctrl == CTRL_START) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sel   = sel_d;

endmodule

// File: rtl/down_counter.sv
// Loadable modulo-N down counter with start/stop, auto-reload and a one-cycle
// terminal-count pulse. Holds the count, reload value and tc flops.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [1:0]       fsm_state;
  logic [1:0]       sel;
  logic             q_zero, q_one, reload_nz;

  assign q_zero    = (q_q == '0);
  assign q_one     = (q_q == WIDTH'(1));
  assign reload_nz = (reload_q != '0);

  down_counter_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .q_zero      (q_zero),
    .q_one       (q_one),
    .reload_nz   (reload_nz),
    .state       (fsm_state),
    .busy        (busy),
    .done        (done),
    .sel         (sel)
  );

  // tc marks the decrement that lands on zero; load and hold paths never raise it.
  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (sel)
      SEL_LOAD: begin
        q_d      = load_val;
        reload_d = load_val;
      end
      SEL_DEC: begin
        q_d  = q_q - WIDTH'(1);
        tc_d = (fsm_state == RUN) && q_one;
      end
      SEL_RELOAD: q_d = reload_q;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule
